// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage MIPS pipeline: load-use, taken-branch and
// imem-wait resolution, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
    output logic             busy_flush
);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    localparam logic [3:0] FCNT_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] fcnt, fcnt_nxt;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // NOTE: every output and next-state value is defaulted first so no path infers a latch.
    always_comb begin
        state_nxt    = state;
        fcnt_nxt     = fcnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        busy_flush   = 1'b0;

        unique case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = FLUSH;
                        fcnt_nxt  = FCNT_RELOAD;
                    end
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (!imem_ready) begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                end
            end
            FLUSH: begin
                busy_flush  = 1'b1;
                if_id_flush = 1'b1;
                if (ex_branch_taken) begin
                    id_ex_bubble = 1'b1;
                    fcnt_nxt     = FCNT_RELOAD;
                    if (FLUSH_CYCLES <= 1) state_nxt = RUN;
                end else begin
                    pc_write = imem_ready;
                    if (imem_ready) begin
                        // fcnt counts the flush cycles still owed, including this one
                        if (fcnt == 4'd1) state_nxt = RUN;
                        fcnt_nxt = fcnt - 4'd1;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            busy_flush   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            fcnt         <= 4'd0;
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (!pc_write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (if_id_flush && (flush_cycles != '1))
                flush_cycles <= flush_cycles + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It drives PC write-enable, IF/ID write-enable, the IF/ID flush and the ID/EX bubble-insert. It resolves three event types: load-use hazards, taken branches/jumps resolved in EX, and instruction-memory wait. It also keeps saturating performance counters for stall and flush cycles.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is flushed after a taken branch (1..15)
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous, active-high reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rt  input  1  ID instruction reads rt as a source
ex_mem_read  input  1  instruction in EX is a load
ex_rt  input  5  destination rt of instruction in EX
ex_branch_taken  input  1  branch/jump in EX redirects PC this cycle
imem_ready  input  1  instruction memory returns valid fetch this cycle
pc_write  output  1  PC register load enable
if_id_write  output  1  IF/ID register load enable
if_id_flush  output  1  IF/ID loads a NOP (32'd0) instead of the fetched instruction
id_ex_bubble  output  1  ID/EX loads control zeros (bubble)
stall_cycles  output  CNT_W  count of load-use plus imem-wait stall cycles
flush_cycles  output  CNT_W  count of cycles with if_id_flush high
busy_flush  output  1  high while in FLUSH state

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, on rst.
- While rst=1: state=RUN, flush counter=0, stall_cycles=0, flush_cycles=0. Outputs are forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, busy_flush=0.
- Control outputs are combinational from the current state and inputs, with zero latency. Counters and state are registered.
- load_use = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- States:
  - RUN: normal operation.
  - FLUSH: post-branch flush window. It holds an internal counter fcnt (4 bits).
- RUN priority, highest first:
  1. ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1. If FLUSH_CYCLES>1, go to FLUSH with fcnt=FLUSH_CYCLES-1. Load-use and imem wait are ignored this cycle.
  2. load_use: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1. Exactly one bubble is inserted, because the next cycle EX holds the bubble and load_use falls.
  3. !imem_ready: pc_write=0, if_id_write=1, if_id_flush=1, id_ex_bubble=0. The ID instruction proceeds and a NOP enters ID.
  4. Otherwise: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- FLUSH state:
  - Outputs: if_id_write=1, if_id_flush=1, id_ex_bubble=0, pc_write=imem_ready, busy_flush=1.
  - fcnt decrements only when imem_ready=1. Return to RUN when fcnt==1 and imem_ready=1.
  - A new ex_branch_taken in FLUSH produces the RUN-branch outputs and reloads fcnt=FLUSH_CYCLES-1. If FLUSH_CYCLES-1==0, go to RUN.
  - load_use is ignored in FLUSH.
- Counters:
  - stall_cycles increments on every cycle where pc_write=0 and rst=0.
  - flush_cycles increments on every cycle where if_id_flush=1 and rst=0.
  - Both saturate at all-ones with no wrap.
- Reset asserted mid-FLUSH returns to RUN immediately. No pending flush survives reset.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5, imem_ready=1 for one cycle, then ex_mem_read=0 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles=1.
- Register-0 and rt filtering: ex_rt=0=id_rs with a load present -> no stall. ex_rt=7=id_rt with id_uses_rt=0 -> no stall. Same case with id_uses_rt=1 -> one-cycle stall.
- Branch with simultaneous load_use, FLUSH_CYCLES=1 -> branch wins: pc_write=1, if_id_flush=1, id_ex_bubble=1 for one cycle; busy_flush stays 0; flush_cycles=1.
- FLUSH_CYCLES=3: branch, then imem_ready=0 for 2 cycles inside FLUSH -> if_id_flush high 5 cycles total; pc_write low during the 2 wait cycles; return to RUN afterwards.
- imem_ready=0 for 4 cycles in RUN -> pc_write=0, if_id_write=1, if_id_flush=1 each cycle; stall_cycles=4 and flush_cycles=4.
- Assert rst in the middle of FLUSH, then deassert -> state RUN, counters 0, and next idle cycle shows pc_write=1, if_id_flush=0. Separately, preload counters near all-ones (CNT_W=4) -> they saturate at 15.
